serial_addsub: RTL and testbench
================================

SERIAL_ADDSUB -- requirements
Module: serial_addsub

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  request a new operation; sampled only in IDLE.
REQ-005 SHALL have port sub  input  1  0 = A+B, 1 = A-B; sampled with start.
REQ-006 SHALL have port a  input  WIDTH  operand A, two's complement; sampled with start.
REQ-007 SHALL have port b  input  WIDTH  operand B, two's complement; sampled with start.
REQ-008 SHALL have port busy  output  1  high while state is not IDLE.
REQ-009 SHALL have port done  output  1  one-cycle pulse when result and flags become valid.
REQ-010 SHALL have port result  output  WIDTH  final sum/difference; held until the next accepted start.
REQ-011 SHALL have port ovf  output  1  signed overflow of the completed operation.
REQ-012 SHALL have port zero  output  1  result == 0.
REQ-013 SHALL have port neg  output  1  result MSB.

Function
REQ-014 SHALL implement states IDLE, SHIFT, DONE; IDLE->SHIFT on start, SHIFT->DONE after bit WIDTH-1, DONE->IDLE unconditionally.
REQ-015 SHALL, on start in IDLE, latch a, b XOR {WIDTH{sub}} and sub into internal shift registers and set carry flop to sub, bit counter to 0.
REQ-016 SHALL in SHIFT process exactly one bit per cycle, LSB first, using one full-adder cell: sum = a0^b0^c, carry = majority(a0,b0,c); carry flop updates each cycle.
REQ-017 SHALL shift the sum bit into the result register MSB end so that after WIDTH cycles bit i of the result equals bit i of the sum.
REQ-018 SHALL record the carry into the MSB position and the carry out of it; ovf = carry_in_msb XOR carry_out_msb.
REQ-019 SHALL assert done exactly WIDTH+1 rising edges after the edge accepting start; busy high from the edge after acceptance through the DONE cycle inclusive.
REQ-020 SHALL update result, ovf, zero, neg on entry to DONE only; they are stable whenever done is high and remain unchanged in IDLE.
REQ-021 SHALL ignore start (and a, b, sub) while in SHIFT or DONE; no queuing.
REQ-022 SHALL wrap modulo 2^WIDTH (unsigned carry-out discarded) when saturation is not compiled in.

Reset
REQ-023 SHALL on rst, regardless of clock, force state IDLE, busy=0, done=0, result=0, ovf=0, zero=0, neg=0, carry flop and counter 0.
REQ-024 SHALL abort any in-flight operation on rst mid-SHIFT with no done pulse; first start after rst deasserts begins a fresh operation.

Configuration
REQ-025 SHALL, with macro SERIAL_ADDSUB_SAT_EN defined, clamp result on overflow to 2^(WIDTH-1)-1 if latched A MSB is 0, else to -2^(WIDTH-1); ovf still reports 1; zero/neg computed from the clamped value.
REQ-026 SHALL, without SERIAL_ADDSUB_SAT_EN, output the wrapped result per REQ-022; latency identical in both builds.

Verification (WIDTH=16)
REQ-027 SHALL cover a=0x0003, b=0x0004, sub=0 -> done on 17th edge after start, result=0x0007, ovf=0, zero=0, neg=0.
REQ-028 SHALL cover a=0x7FFF, b=0x0001, sub=0 -> ovf=1, neg=1, result=0x8000 (no macro) / 0x7FFF with neg=0 (SAT_EN).
REQ-029 SHALL cover a=0x8000, b=0x0001, sub=1 -> ovf=1, result=0x7FFF (no macro) / 0x8000 (SAT_EN).
REQ-030 SHALL cover a=0x0005, b=0x0005, sub=1 -> result=0x0000, zero=1, ovf=0; then a=0x0000, b=0x0001, sub=1 -> 0xFFFF, neg=1.
REQ-031 SHALL cover start pulsed with new operands on cycle 5 of SHIFT -> ignored, first result unchanged, single done pulse.
REQ-032 SHALL cover rst asserted on cycle 8 of SHIFT -> all outputs 0 immediately, no done; next operation 0x1234+0x0001 yields 0x1235 with normal latency.

Source files
------------

// File: rtl/serial_addsub.sv
// Bit-serial two's-complement adder/subtractor: one full-adder cell, LSB first, WIDTH+1 cycle latency.
// Define SERIAL_ADDSUB_SAT_EN to clamp overflowed results to the signed range instead of wrapping.
module serial_addsub #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr, b_sr, sum_sr;
  logic [CW-1:0]    cnt;
  logic             carry, c_in_msb, c_out_msb, a_msb;

  logic             fa_sum, fa_cout, ovf_w;
  logic [WIDTH-1:0] final_w;

  // Single full-adder cell shared by every bit position.
  always_comb begin
    fa_sum  = a_sr[0] ^ b_sr[0] ^ carry;
    fa_cout = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
  end

  always_comb begin
    ovf_w   = c_in_msb ^ c_out_msb;
    final_w = sum_sr;
`ifdef SERIAL_ADDSUB_SAT_EN
    if (ovf_w)
      final_w = a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
  end

  // Status outputs are registered and trail the state by one edge, so done
  // rises exactly WIDTH+1 edges after the accepting edge with busy still high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: every register, datapath included, is cleared so an aborted
      // operation leaves no residue in the next one.
      state     <= IDLE;
      a_sr      <= '0;
      b_sr      <= '0;
      sum_sr    <= '0;
      cnt       <= '0;
      carry     <= 1'b0;
      c_in_msb  <= 1'b0;
      c_out_msb <= 1'b0;
      a_msb     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
      neg       <= 1'b0;
    end else begin
      done <= 1'b0;
      busy <= (state != IDLE);
      case (state)
        IDLE: begin
          if (start) begin
            // Subtraction is A + ~B + 1: invert B and preload the carry.
            a_sr  <= a;
            b_sr  <= b ^ {WIDTH{sub}};
            carry <= sub;
            a_msb <= a[WIDTH-1];
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          sum_sr <= {fa_sum, sum_sr[WIDTH-1:1]};
          carry  <= fa_cout;
          cnt    <= cnt + CW'(1);
          if (cnt == CW'(WIDTH-1)) begin
            c_in_msb  <= carry;
            c_out_msb <= fa_cout;
            state     <= DONE;
          end
        end
        DONE: begin
          result <= final_w;
          ovf    <= ovf_w;
          zero   <= (final_w == '0);
          neg    <= final_w[WIDTH-1];
          done   <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub (WIDTH=16); define SERIAL_ADDSUB_SAT_EN to check the saturating build.
module tb_serial_addsub;

  localparam int W = 16;

  typedef struct {
    logic [W-1:0] res;
    logic         ovf;
    logic         zero;
    logic         neg;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         sub;
  logic [W-1:0] a, b;
  logic         busy, done, ovf, zero, neg;
  logic [W-1:0] result;

  int   ntests = 0;
  int   nfail  = 0;
  exp_t sb[$];

  serial_addsub #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .ovf(ovf), .zero(zero), .neg(neg)
  );

  always #5 clk = ~clk;

  // Reference: whole-word arithmetic, overflow from operand/result signs.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    exp_t         e;
    logic [W-1:0] yy;
    yy    = s ? (~y + 1'b1) : y;
    e.res = x + yy;
    if (s) e.ovf = (x[W-1] != y[W-1]) && (e.res[W-1] != x[W-1]);
    else   e.ovf = (x[W-1] == y[W-1]) && (e.res[W-1] != x[W-1]);
`ifdef SERIAL_ADDSUB_SAT_EN
    if (e.ovf) e.res = x[W-1] ? 16'h8000 : 16'h7FFF;
`endif
    e.zero = (e.res == '0);
    e.neg  = e.res[W-1];
    return e;
  endfunction

  // Runs one operation; optionally pulses start with junk operands on SHIFT cycle inject_at.
  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                       input int inject_at, input string name);
    exp_t e;
    int   lat, extra;
    @(negedge clk);
    ntests++;
    if (busy !== 1'b0) begin nfail++; $display("FAIL %s idle_busy: got %b want 0", name, busy); end
    a = x; b = y; sub = s; start = 1'b1;
    sb.push_back(model(x, y, s));
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom; sub = $urandom_range(0, 1);
    lat = 0;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      if (k == inject_at) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      if (done === 1'b1) lat = k;
    end
    ntests++;
    if (lat != W + 1) begin nfail++; $display("FAIL %s latency: got %0d want %0d", name, lat, W + 1); end
    if (lat != 0) begin
      e = sb.pop_front();
      ntests += 5;
      if (result !== e.res) begin nfail++; $display("FAIL %s result: got %h want %h", name, result, e.res); end
      if (ovf !== e.ovf)    begin nfail++; $display("FAIL %s ovf: got %b want %b", name, ovf, e.ovf); end
      if (zero !== e.zero)  begin nfail++; $display("FAIL %s zero: got %b want %b", name, zero, e.zero); end
      if (neg !== e.neg)    begin nfail++; $display("FAIL %s neg: got %b want %b", name, neg, e.neg); end
      if (busy !== 1'b1)    begin nfail++; $display("FAIL %s busy_at_done: got %b want 1", name, busy); end
      extra = 0;
      for (int k = 0; k < 20; k++) begin
        @(posedge clk); #1;
        if (done === 1'b1) extra++;
      end
      ntests += 2;
      if (extra != 0)       begin nfail++; $display("FAIL %s extra_done: got %0d want 0", name, extra); end
      if (result !== e.res) begin nfail++; $display("FAIL %s result_held: got %h want %h", name, result, e.res); end
    end else begin
      void'(sb.pop_front());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    ntests++;
    if ({busy, done, result, ovf, zero, neg} !== '0) begin
      nfail++; $display("FAIL reset_outputs: got busy=%b done=%b res=%h ovf=%b zero=%b neg=%b want all 0",
                        busy, done, result, ovf, zero, neg);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_arith();
    do_op(16'h0003, 16'h0004, 1'b0, 0, "add_3_4");
    do_op(16'h7FFF, 16'h0001, 1'b0, 0, "add_ovf_pos");
    do_op(16'h8000, 16'h0001, 1'b1, 0, "sub_ovf_neg");
    do_op(16'h0005, 16'h0005, 1'b1, 0, "sub_zero");
    do_op(16'h0000, 16'h0001, 1'b1, 0, "sub_neg");
    do_op(16'h8000, 16'h8000, 1'b0, 0, "add_min_min");
    for (int i = 0; i < 6; i++)
      do_op(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 0, "random");
  endtask

  task automatic test_ignore_start();
    do_op(16'h1111, 16'h2222, 1'b0, 5, "ignore_start");
  endtask

  task automatic test_reset_abort();
    int dones;
    @(negedge clk);
    a = 16'h00FF; b = 16'h0F0F; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (8) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    ntests++;
    if ({busy, done, result, ovf, zero, neg} !== '0) begin
      nfail++; $display("FAIL abort_outputs: got busy=%b done=%b res=%h ovf=%b zero=%b neg=%b want all 0",
                        busy, done, result, ovf, zero, neg);
    end
    @(negedge clk); @(negedge clk); rst = 1'b0;
    dones = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) dones++;
    end
    ntests++;
    if (dones != 0) begin nfail++; $display("FAIL abort_no_done: got %0d pulses want 0", dones); end
    do_op(16'h1234, 16'h0001, 1'b0, 0, "after_abort");
  endtask

  initial begin
    test_reset();
    test_arith();
    test_ignore_start();
    test_reset_abort();
    ntests++;
    if (sb.size() != 0) begin nfail++; $display("FAIL scoreboard_drain: got %0d left want 0", sb.size()); end
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
